// File: rtl/eu_ybuf_sched.sv
// Single-issue operand fetch / writeback scheduler in front of the exec-unit y buffer.
// Reads retry until success, the result write retries until acknowledged, and both are bounded by MAX_RETRY.
module eu_ybuf_sched #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_RETRY  = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_valid_i,
    output logic                  instr_ready_o,
    input  logic [ADDR_WIDTH-1:0] instr_op0_addr_i,
    input  logic                  instr_op0_use_i,
    input  logic [ADDR_WIDTH-1:0] instr_op1_addr_i,
    input  logic                  instr_op1_use_i,
    input  logic [DATA_WIDTH-1:0] instr_imm_i,
    input  logic [ADDR_WIDTH-1:0] instr_res_addr_i,
    output logic [ADDR_WIDTH-1:0] yb_op0_req_addr_o,
    output logic                  yb_op0_req_valid_o,
    input  logic [DATA_WIDTH-1:0] yb_op0_data_i,
    input  logic                  yb_op0_success_i,
    output logic [ADDR_WIDTH-1:0] yb_op1_req_addr_o,
    output logic                  yb_op1_req_valid_o,
    input  logic [DATA_WIDTH-1:0] yb_op1_data_i,
    input  logic                  yb_op1_success_i,
    output logic [ADDR_WIDTH-1:0] yb_result_addr_o,
    output logic [DATA_WIDTH-1:0] yb_result_data_o,
    output logic                  yb_result_valid_o,
    input  logic                  yb_result_success_i,
    output logic                  alu_valid_o,
    input  logic                  alu_ready_i,
    output logic [DATA_WIDTH-1:0] alu_op0_o,
    output logic [DATA_WIDTH-1:0] alu_op1_o,
    input  logic                  alu_res_valid_i,
    input  logic [DATA_WIDTH-1:0] alu_res_data_i,
    output logic                  done_o,
    output logic                  err_o,
    output logic [1:0]            err_code_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_ISSUE   = 3'd2,
        S_WB_WAIT = 3'd3,
        S_WB_REQ  = 3'd4,
        S_WB_CHK  = 3'd5
    } state_t;

    localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);

    state_t                state_r;
    logic [7:0]            retry_r;
    logic [ADDR_WIDTH-1:0] op0_addr_r;
    logic [ADDR_WIDTH-1:0] op1_addr_r;
    logic [ADDR_WIDTH-1:0] res_addr_r;
    logic                  pend0_r;
    logic                  pend1_r;
    logic                  req0_prev_r;
    logic                  req1_prev_r;
    logic [DATA_WIDTH-1:0] op0_r;
    logic [DATA_WIDTH-1:0] op1_r;
    logic [DATA_WIDTH-1:0] res_data_r;
    logic                  err_r;
    logic [1:0]            err_code_r;

    logic                  cap0_s;
    logic                  cap1_s;
    logic                  pend0_nxt_s;
    logic                  pend1_nxt_s;
    logic                  fetch_to_s;
    logic                  wb_to_s;
    logic                  alu_unexp_s;
    logic                  err_s;
    logic [1:0]            err_code_s;

    assign instr_ready_o      = (state_r == S_IDLE);
    assign yb_op0_req_valid_o = (state_r == S_FETCH) && pend0_r;
    assign yb_op1_req_valid_o = (state_r == S_FETCH) && pend1_r;
    assign yb_op0_req_addr_o  = op0_addr_r;
    assign yb_op1_req_addr_o  = op1_addr_r;
    assign yb_result_valid_o  = (state_r == S_WB_REQ);
    assign yb_result_addr_o   = res_addr_r;
    assign yb_result_data_o   = res_data_r;
    assign alu_valid_o        = (state_r == S_ISSUE);
    assign alu_op0_o          = op0_r;
    assign alu_op1_o          = op1_r;
    assign done_o             = (state_r == S_WB_CHK) && yb_result_success_i;
    assign err_o              = err_r;
    assign err_code_o         = err_code_r;

    // Read-response capture: only a response to a request made last cycle counts.
    always_comb begin
        cap0_s      = 1'b0;
        cap1_s      = 1'b0;
        if (state_r == S_FETCH) begin
            cap0_s = pend0_r && req0_prev_r && yb_op0_success_i;
            cap1_s = pend1_r && req1_prev_r && yb_op1_success_i;
        end else begin
            cap0_s = 1'b0;
            cap1_s = 1'b0;
        end
        pend0_nxt_s = pend0_r && !cap0_s;
        pend1_nxt_s = pend1_r && !cap1_s;
    end

    // Error detection; timeouts outrank the stray ALU result.
    always_comb begin
        fetch_to_s  = (state_r == S_FETCH) && (pend0_nxt_s || pend1_nxt_s) &&
                      !(cap0_s || cap1_s) && (retry_r == RETRY_MAX);
        wb_to_s     = (state_r == S_WB_CHK) && !yb_result_success_i && (retry_r == RETRY_MAX);
        alu_unexp_s = alu_res_valid_i && (state_r != S_WB_WAIT);
        err_s       = fetch_to_s || wb_to_s || alu_unexp_s;
        if (fetch_to_s) begin
            err_code_s = 2'b01;
        end else if (wb_to_s) begin
            err_code_s = 2'b10;
        end else if (alu_unexp_s) begin
            err_code_s = 2'b11;
        end else begin
            err_code_s = 2'b00;
        end
    end

    // Scheduler FSM with its datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            retry_r     <= 8'd0;
            op0_addr_r  <= {ADDR_WIDTH{1'b0}};
            op1_addr_r  <= {ADDR_WIDTH{1'b0}};
            res_addr_r  <= {ADDR_WIDTH{1'b0}};
            pend0_r     <= 1'b0;
            pend1_r     <= 1'b0;
            req0_prev_r <= 1'b0;
            req1_prev_r <= 1'b0;
            op0_r       <= {DATA_WIDTH{1'b0}};
            op1_r       <= {DATA_WIDTH{1'b0}};
            res_data_r  <= {DATA_WIDTH{1'b0}};
            err_r       <= 1'b0;
            err_code_r  <= 2'b00;
        end else begin
            err_r       <= err_s;
            err_code_r  <= err_code_s;
            req0_prev_r <= yb_op0_req_valid_o;
            req1_prev_r <= yb_op1_req_valid_o;
            case (state_r)
                S_IDLE: begin
                    if (instr_valid_i) begin
                        op0_addr_r <= instr_op0_addr_i;
                        op1_addr_r <= instr_op1_addr_i;
                        res_addr_r <= instr_res_addr_i;
                        pend0_r    <= instr_op0_use_i;
                        pend1_r    <= instr_op1_use_i;
                        op0_r      <= {DATA_WIDTH{1'b0}};
                        op1_r      <= instr_op1_use_i ? {DATA_WIDTH{1'b0}} : instr_imm_i;
                        retry_r    <= 8'd0;
                        state_r    <= (instr_op0_use_i || instr_op1_use_i) ? S_FETCH : S_ISSUE;
                    end
                end
                S_FETCH: begin
                    if (cap0_s) begin
                        op0_r <= yb_op0_data_i;
                    end
                    if (cap1_s) begin
                        op1_r <= yb_op1_data_i;
                    end
                    pend0_r <= pend0_nxt_s;
                    pend1_r <= pend1_nxt_s;
                    // The first FETCH cycle has no response to count.
                    if (cap0_s || cap1_s) begin
                        retry_r <= 8'd0;
                    end else if (req0_prev_r || req1_prev_r) begin
                        retry_r <= retry_r + 8'd1;
                    end
                    if (fetch_to_s) begin
                        state_r <= S_IDLE;
                    end else if (!pend0_nxt_s && !pend1_nxt_s) begin
                        state_r <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (alu_ready_i) begin
                        state_r <= S_WB_WAIT;
                    end
                end
                S_WB_WAIT: begin
                    if (alu_res_valid_i) begin
                        res_data_r <= alu_res_data_i;
                        retry_r    <= 8'd0;
                        state_r    <= S_WB_REQ;
                    end
                end
                S_WB_REQ: begin
                    state_r <= S_WB_CHK;
                end
                S_WB_CHK: begin
                    if (yb_result_success_i || wb_to_s) begin
                        state_r <= S_IDLE;
                    end else begin
                        retry_r <= retry_r + 8'd1;
                        state_r <= S_WB_REQ;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eu_ybuf_sched.sv
// Directed bench for eu_ybuf_sched: cycle tables for the normal flows plus
// hand-written retry, timeout, stray-result and reset sequences (MAX_RETRY=4).
module tb_eu_ybuf_sched;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int MR = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          instr_valid_i;
    logic          instr_ready_o;
    logic [AW-1:0] instr_op0_addr_i;
    logic          instr_op0_use_i;
    logic [AW-1:0] instr_op1_addr_i;
    logic          instr_op1_use_i;
    logic [DW-1:0] instr_imm_i;
    logic [AW-1:0] instr_res_addr_i;
    logic [AW-1:0] yb_op0_req_addr_o;
    logic          yb_op0_req_valid_o;
    logic [DW-1:0] yb_op0_data_i;
    logic          yb_op0_success_i;
    logic [AW-1:0] yb_op1_req_addr_o;
    logic          yb_op1_req_valid_o;
    logic [DW-1:0] yb_op1_data_i;
    logic          yb_op1_success_i;
    logic [AW-1:0] yb_result_addr_o;
    logic [DW-1:0] yb_result_data_o;
    logic          yb_result_valid_o;
    logic          yb_result_success_i;
    logic          alu_valid_o;
    logic          alu_ready_i;
    logic [DW-1:0] alu_op0_o;
    logic [DW-1:0] alu_op1_o;
    logic          alu_res_valid_i;
    logic [DW-1:0] alu_res_data_i;
    logic          done_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    always #5 clk = ~clk;

    eu_ybuf_sched #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_op0_addr_i(instr_op0_addr_i), .instr_op0_use_i(instr_op0_use_i),
        .instr_op1_addr_i(instr_op1_addr_i), .instr_op1_use_i(instr_op1_use_i),
        .instr_imm_i(instr_imm_i), .instr_res_addr_i(instr_res_addr_i),
        .yb_op0_req_addr_o(yb_op0_req_addr_o), .yb_op0_req_valid_o(yb_op0_req_valid_o),
        .yb_op0_data_i(yb_op0_data_i), .yb_op0_success_i(yb_op0_success_i),
        .yb_op1_req_addr_o(yb_op1_req_addr_o), .yb_op1_req_valid_o(yb_op1_req_valid_o),
        .yb_op1_data_i(yb_op1_data_i), .yb_op1_success_i(yb_op1_success_i),
        .yb_result_addr_o(yb_result_addr_o), .yb_result_data_o(yb_result_data_o),
        .yb_result_valid_o(yb_result_valid_o), .yb_result_success_i(yb_result_success_i),
        .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
        .alu_op0_o(alu_op0_o), .alu_op1_o(alu_op1_o),
        .alu_res_valid_i(alu_res_valid_i), .alu_res_data_i(alu_res_data_i),
        .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    // flags = {ready, req0, req1, alu_valid, res_valid, done, err, err_code[1:0]}
    typedef struct {
        logic        vld;
        logic        u0;
        logic        u1;
        logic [31:0] imm;
        logic        s0;
        logic        s1;
        logic        arv;
        logic [8:0]  f;
        logic [31:0] o0;
        logic [31:0] o1;
    } row_t;

    row_t rows[19];
    int   checks = 0;
    int   errors = 0;

    function automatic row_t mk(input logic vld, input logic u0, input logic u1,
                                input logic [31:0] imm, input logic s0, input logic s1,
                                input logic arv, input logic [8:0] f,
                                input logic [31:0] o0, input logic [31:0] o1);
        row_t r;
        r.vld = vld; r.u0 = u0; r.u1 = u1; r.imm = imm; r.s0 = s0; r.s1 = s1;
        r.arv = arv; r.f = f; r.o0 = o0; r.o1 = o1;
        return r;
    endfunction

    function automatic logic [8:0] flags();
        return {instr_ready_o, yb_op0_req_valid_o, yb_op1_req_valid_o, alu_valid_o,
                yb_result_valid_o, done_o, err_o, err_code_o};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            tick();
            instr_valid_i       = rows[i].vld;
            instr_op0_use_i     = rows[i].u0;
            instr_op1_use_i     = rows[i].u1;
            instr_imm_i         = rows[i].imm;
            yb_op0_success_i    = rows[i].s0;
            yb_op1_success_i    = rows[i].s1;
            alu_res_valid_i     = rows[i].arv;
            alu_ready_i         = 1'b1;
            yb_result_success_i = 1'b1;
            #1;
            chk($sformatf("row%0d flags", i), 32'(flags()), 32'(rows[i].f));
            if (rows[i].f[7]) chk($sformatf("row%0d op0 addr", i), 32'(yb_op0_req_addr_o), 32'd3);
            if (rows[i].f[6]) chk($sformatf("row%0d op1 addr", i), 32'(yb_op1_req_addr_o), 32'd5);
            if (rows[i].f[5]) begin
                chk($sformatf("row%0d alu_op0", i), alu_op0_o, rows[i].o0);
                chk($sformatf("row%0d alu_op1", i), alu_op1_o, rows[i].o1);
            end
            if (rows[i].f[4]) begin
                chk($sformatf("row%0d res addr", i), 32'(yb_result_addr_o), 32'd9);
                chk($sformatf("row%0d res data", i), yb_result_data_o, 32'h15);
            end
        end
        instr_valid_i   = 1'b0;
        alu_res_valid_i = 1'b0;
    endtask

    initial begin
        int nerr;
        int errc;
        int nav;
        int nr0;
        int nstr;
        int nd;
        logic [1:0] code_seen;
        logic rdy_at_err;

        // both operands, immediate success
        rows[0]  = mk(1'b1, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b1_00_0_0_0_0_00, 32'h0, 32'h0);
        rows[1]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b0_11_0_0_0_0_00, 32'h0, 32'h0);
        rows[2]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b0_11_0_0_0_0_00, 32'h0, 32'h0);
        rows[3]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b0_00_1_0_0_0_00, 32'hA, 32'hB);
        rows[4]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b1, 9'b0_00_0_0_0_0_00, 32'h0, 32'h0);
        rows[5]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b0_00_0_1_0_0_00, 32'h0, 32'h0);
        rows[6]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b0_00_0_0_1_0_00, 32'h0, 32'h0);
        rows[7]  = mk(1'b0, 1'b1, 1'b1, 32'h55, 1'b1, 1'b1, 1'b0, 9'b1_00_0_0_0_0_00, 32'h0, 32'h0);
        // op1 from immediate, op0 success withheld for three responses
        rows[8]  = mk(1'b1, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, 9'b1_00_0_0_0_0_00, 32'h0, 32'h0);
        rows[9]  = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, 9'b0_10_0_0_0_0_00, 32'h0, 32'h0);
        rows[10] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, 9'b0_10_0_0_0_0_00, 32'h0, 32'h0);
        rows[11] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, 9'b0_10_0_0_0_0_00, 32'h0, 32'h0);
        rows[12] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b0, 1'b1, 1'b0, 9'b0_10_0_0_0_0_00, 32'h0, 32'h0);
        rows[13] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 9'b0_10_0_0_0_0_00, 32'h0, 32'h0);
        rows[14] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 9'b0_00_1_0_0_0_00, 32'hA, 32'h7F);
        rows[15] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b1, 9'b0_00_0_0_0_0_00, 32'h0, 32'h0);
        rows[16] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 9'b0_00_0_1_0_0_00, 32'h0, 32'h0);
        rows[17] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 9'b0_00_0_0_1_0_00, 32'h0, 32'h0);
        rows[18] = mk(1'b0, 1'b1, 1'b0, 32'h7F, 1'b1, 1'b1, 1'b0, 9'b1_00_0_0_0_0_00, 32'h0, 32'h0);

        reset = 1'b1;
        instr_valid_i = 1'b0; instr_op0_use_i = 1'b0; instr_op1_use_i = 1'b0;
        instr_op0_addr_i = 4'd3; instr_op1_addr_i = 4'd5; instr_res_addr_i = 4'd9;
        instr_imm_i = 32'h0;
        yb_op0_data_i = 32'hA; yb_op1_data_i = 32'hB;
        yb_op0_success_i = 1'b0; yb_op1_success_i = 1'b0; yb_result_success_i = 1'b0;
        alu_ready_i = 1'b0; alu_res_valid_i = 1'b0; alu_res_data_i = 32'h15;
        repeat (2) tick();
        #1;
        chk("reset flags", 32'(flags()), 32'(9'b1_00_0_0_0_0_00));
        chk("reset alu_op1", alu_op1_o, 32'h0);
        reset = 1'b0;

        run_rows(0, 18);

        // fetch timeout: op1 never succeeds
        tick();
        instr_valid_i = 1'b1; instr_op0_use_i = 1'b0; instr_op1_use_i = 1'b1;
        yb_op1_success_i = 1'b0; yb_op0_success_i = 1'b1; alu_ready_i = 1'b1;
        nerr = 0; errc = -1; nav = 0; nr0 = 0; code_seen = 2'b00; rdy_at_err = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            tick();
            instr_valid_i = 1'b0;
            #1;
            if (err_o) begin nerr++; errc = c; code_seen = err_code_o; rdy_at_err = instr_ready_o; end
            if (alu_valid_o) nav++;
            if (yb_op0_req_valid_o) nr0++;
        end
        chk("fetch-to err count", 32'(nerr), 32'd1);
        chk("fetch-to err cycle", 32'(errc), 32'd7);
        chk("fetch-to err code", 32'(code_seen), 32'd1);
        chk("fetch-to ready", 32'(rdy_at_err), 32'd1);
        chk("fetch-to alu_valid", 32'(nav), 32'd0);
        chk("fetch-to op0 req", 32'(nr0), 32'd0);

        // writeback: two rejections then acceptance
        tick();
        instr_valid_i = 1'b1; instr_op0_use_i = 1'b0; instr_op1_use_i = 1'b0;
        instr_imm_i = 32'h33; yb_result_success_i = 1'b0;
        nstr = 0; nd = 0; nerr = 0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            instr_valid_i = 1'b0;
            alu_res_valid_i = (c == 2);
            yb_result_success_i = (nstr >= 3);
            #1;
            if (alu_valid_o) begin
                chk("wb alu_op0", alu_op0_o, 32'h0);
                chk("wb alu_op1", alu_op1_o, 32'h33);
            end
            if (yb_result_valid_o) begin
                nstr++;
                chk($sformatf("wb strobe%0d addr", nstr), 32'(yb_result_addr_o), 32'd9);
                chk($sformatf("wb strobe%0d data", nstr), yb_result_data_o, 32'h15);
            end
            if (done_o) nd++;
            if (err_o) nerr++;
        end
        chk("wb retry strobes", 32'(nstr), 32'd3);
        chk("wb retry done", 32'(nd), 32'd1);
        chk("wb retry err", 32'(nerr), 32'd0);

        // writeback timeout: never acknowledged
        tick();
        instr_valid_i = 1'b1; yb_result_success_i = 1'b0;
        nstr = 0; nd = 0; nerr = 0; code_seen = 2'b00;
        for (int c = 1; c <= 20; c++) begin
            tick();
            instr_valid_i = 1'b0;
            alu_res_valid_i = (c == 2);
            #1;
            if (yb_result_valid_o) nstr++;
            if (done_o) nd++;
            if (err_o) begin nerr++; code_seen = err_code_o; end
        end
        chk("wb-to strobes", 32'(nstr), 32'(MR + 1));
        chk("wb-to err count", 32'(nerr), 32'd1);
        chk("wb-to err code", 32'(code_seen), 32'd2);
        chk("wb-to done", 32'(nd), 32'd0);

        // stray ALU result during FETCH
        tick();
        instr_valid_i = 1'b1; instr_op0_use_i = 1'b1; instr_op1_use_i = 1'b1;
        yb_op0_success_i = 1'b1; yb_op1_success_i = 1'b1; yb_result_success_i = 1'b1;
        nd = 0; nerr = 0; errc = -1; code_seen = 2'b00;
        for (int c = 1; c <= 12; c++) begin
            tick();
            instr_valid_i = 1'b0;
            alu_res_valid_i = (c == 1) || (c == 4);
            #1;
            if (alu_valid_o) begin
                chk("stray alu_op0", alu_op0_o, 32'hA);
                chk("stray alu_op1", alu_op1_o, 32'hB);
            end
            if (err_o) begin nerr++; errc = c; code_seen = err_code_o; end
            if (done_o) nd++;
        end
        alu_res_valid_i = 1'b0;
        chk("stray err count", 32'(nerr), 32'd1);
        chk("stray err cycle", 32'(errc), 32'd2);
        chk("stray err code", 32'(code_seen), 32'd3);
        chk("stray done", 32'(nd), 32'd1);

        // reset in the middle of WB_REQ
        tick();
        instr_valid_i = 1'b1; instr_op0_use_i = 1'b0; instr_op1_use_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            instr_valid_i = 1'b0;
            alu_res_valid_i = (c == 2);
        end
        #1;
        chk("pre-reset res_valid", 32'(yb_result_valid_o), 32'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("mid-reset flags", 32'(flags()), 32'(9'b1_00_0_0_0_0_00));
        chk("mid-reset res data", yb_result_data_o, 32'h0);
        alu_res_valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        run_rows(0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eu_ybuf_sched.md
Name: eu_ybuf_sched

Overview:
Single-issue operand/writeback scheduler placed in front of the exec-unit y buffer. It accepts one instruction at a time and fetches its register operands through the y buffer's two read-request ports, retrying reads that return no success. It then hands the operands to the ALU and writes the ALU result back through the y buffer result port, retrying until the write is acknowledged. Bounded retries convert permanent stalls into error pulses.

Parameters:
ADDR_WIDTH, 4, width of an ALU-local y buffer address
DATA_WIDTH, 32, exec-unit data width
MAX_RETRY, 15, maximum consecutive failed attempts per phase (1..255)

Ports:
clk  in  1  clock
reset  in  1  reset; asynchronous, active-high
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  scheduler can accept (IDLE)
instr_op0_addr_i  in  ADDR_WIDTH  op0 y buffer address
instr_op0_use_i  in  1  op0 read from y buffer (else op0=0)
instr_op1_addr_i  in  ADDR_WIDTH  op1 y buffer address
instr_op1_use_i  in  1  op1 read from y buffer (else op1=instr_imm_i)
instr_imm_i  in  DATA_WIDTH  immediate for op1
instr_res_addr_i  in  ADDR_WIDTH  result address
yb_op0_req_addr_o / yb_op1_req_addr_o  out  ADDR_WIDTH  read addresses
yb_op0_req_valid_o / yb_op1_req_valid_o  out  1  read requests
yb_op0_data_i / yb_op1_data_i  in  DATA_WIDTH  read data, 1 cycle after request
yb_op0_success_i / yb_op1_success_i  in  1  read succeeded, 1 cycle after request
yb_result_addr_o  out  ADDR_WIDTH  write address
yb_result_data_o  out  DATA_WIDTH  write data
yb_result_valid_o  out  1  write strobe
yb_result_success_i  in  1  write acknowledged, 1 cycle after strobe
alu_valid_o  out  1  operands valid to ALU
alu_ready_i  in  1  ALU accepts
alu_op0_o / alu_op1_o  out  DATA_WIDTH  operands
alu_res_valid_i  in  1  ALU result strobe
alu_res_data_i  in  DATA_WIDTH  ALU result
done_o  out  1  instruction retired (pulse)
err_o  out  1  error pulse
err_code_o  out  2  01 fetch timeout, 10 writeback timeout, 11 unexpected ALU result

Behaviour:
- Reset (async, any state): FSM=IDLE, retry counter=0, all captured/pending registers=0, all outputs 0 except instr_ready_o=1. In-flight instruction is dropped.
- States: IDLE, FETCH, ISSUE, WB_WAIT, WB_REQ, WB_CHK.
- IDLE: instr_ready_o=1. On instr_valid_i, latch all instr fields. pend0=op0_use and pend1=op1_use. Unused operands are preloaded (op0=0, op1=imm). Next state is FETCH if any pend bit is set, else ISSUE.
- FETCH: yb_opN_req_valid_o=pendN; addresses are held constant from the latch.
  - Response rule: in cycle t, if pendN and reqN was asserted in t-1 and yb_opN_success_i=1, capture yb_opN_data_i and clear pendN at the clock edge.
  - A duplicate request issued in the capture cycle is harmless; its response is ignored.
  - Retry counter resets on entry and on any capture. Otherwise it increments in each FETCH cycle after the first.
  - Any pend still set with counter==MAX_RETRY: err_o=1, code 01, go to IDLE.
  - All pend clear: go to ISSUE.
- ISSUE: alu_valid_o=1 with operands held stable. On alu_ready_i, go to WB_WAIT.
- WB_WAIT: on alu_res_valid_i, latch data and go to WB_REQ.
- WB_REQ: yb_result_valid_o=1 for exactly one cycle, with latched addr/data. Go to WB_CHK.
- WB_CHK: on yb_result_success_i=1, done_o=1 (combinational, this cycle) and go to IDLE. Otherwise increment the retry counter (reset on WB_REQ entry from WB_WAIT).
  - Counter==MAX_RETRY: err code 10, go to IDLE.
  - Else return to WB_REQ.
- alu_res_valid_i outside WB_WAIT: err_o=1, code 11, data discarded, state unchanged. Fetch and writeback timeouts take priority if they occur in the same cycle.
- err_o/err_code_o are registered one-cycle pulses; err_code_o=0 when err_o=0.
- Minimum latency with both operands used and immediate success:
  - accept cycle 0, FETCH cycles 1-2, ISSUE 3, WB_WAIT 4 (result same cycle), WB_REQ 5, WB_CHK/done 6, IDLE 7.
- Request outputs are 0 outside FETCH; yb_result_valid_o is 0 outside WB_REQ.

Test Plan:
- Reset, then op0=3, op1=5 used, y buffer always succeeds with data 0xA/0xB, ALU ready, result 0x15 at cycle 4 → alu_op0/op1=0xA/0xB in cycle 3; yb_result addr/data strobe cycle 5; done_o cycle 6.
- op1_use=0, imm=0x7F, op0 success withheld 3 cycles → op1 request never asserted; alu_op1_o=0x7F; op0 captured on 4th response; one instruction retires.
- MAX_RETRY=4, op1 success never asserted → err_o with code 01 exactly once, return to IDLE, instr_ready_o=1, no alu_valid_o.
- yb_result_success_i low twice then high → three yb_result_valid_o strobes with identical addr/data, done_o once; with it never high and MAX_RETRY=4 → err code 10.
- alu_res_valid_i pulsed while in FETCH → err code 11; the instruction still completes normally.
- reset asserted mid-WB_REQ → outputs clear immediately (yb_result_valid_o=0, instr_ready_o=1); the next instruction executes cleanly.
